// File: rtl/mole_round_if.sv
// Handshake bundle between the whack-a-mole round sequencer and its neighbours.
// The master side drives start/abort/tick/buttons; the slave side is the sequencer.
interface mole_round_if #(
    parameter int NUM_MOLES = 4
);
    logic                 start_i;
    logic                 abort_i;
    logic                 tick_i;
    logic [NUM_MOLES-1:0] btn_i;
    logic [NUM_MOLES-1:0] mole_oh_o;
    logic [2:0]           window_left_o;
    logic [7:0]           score_o;
    logic [7:0]           misses_o;
    logic [7:0]           round_cnt_o;
    logic                 busy_o;
    logic                 hit_pulse_o;
    logic                 miss_pulse_o;
    logic                 game_over_o;

    modport master (
        output start_i, abort_i, tick_i, btn_i,
        input  mole_oh_o, window_left_o, score_o, misses_o, round_cnt_o,
               busy_o, hit_pulse_o, miss_pulse_o, game_over_o
    );

    modport slave (
        input  start_i, abort_i, tick_i, btn_i,
        output mole_oh_o, window_left_o, score_o, misses_o, round_cnt_o,
               busy_o, hit_pulse_o, miss_pulse_o, game_over_o
    );
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: arm delay, random pop, reaction window, hit/miss scoring.
// Optional macro SPEED_RAMP_EN shrinks the reaction window after every RAMP_HITS hits.
module mole_round_ctrl #(
    parameter int         NUM_MOLES   = 4,
    parameter int         NUM_ROUNDS  = 16,
    parameter logic [2:0] BASE_WINDOW = 3'd5,
    parameter logic [2:0] ARM_DELAY   = 3'd1,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
`ifdef SPEED_RAMP_EN
    ,
    parameter int         RAMP_HITS   = 4
`endif
) (
    input logic         clk,
    input logic         rst_n,
    mole_round_if.slave bus
);
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {IDLE, ARM, POP, UP, HIT, MISS, DONE} state_t;

    state_t               state_q;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [2:0]           arm_cnt_q, cur_window_q, window_left_q;
    logic [2:0]           last_idx_q, raw_idx, pop_idx;
    logic                 have_last_q;
    logic [NUM_MOLES-1:0] mole_oh_q;
    logic [7:0]           score_q, misses_q, round_cnt_q;
    logic                 busy_q, hit_pulse_q, miss_pulse_q, game_over_q;
`ifdef SPEED_RAMP_EN
    logic [7:0]           ramp_cnt_q;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Galois form of x^8+x^6+x^5+x^4+1, free-running so player timing feeds the pick.
    assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    always_comb begin
        raw_idx = 3'(lfsr_q % NUM_MOLES);
        pop_idx = raw_idx;
        if (have_last_q && (raw_idx == last_idx_q))
            pop_idx = 3'((raw_idx + 1) % NUM_MOLES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            arm_cnt_q     <= 3'd0;
            cur_window_q  <= BASE_WINDOW;
            window_left_q <= 3'd0;
            last_idx_q    <= 3'd0;
            have_last_q   <= 1'b0;
            mole_oh_q     <= '0;
            score_q       <= 8'd0;
            misses_q      <= 8'd0;
            round_cnt_q   <= 8'd0;
            busy_q        <= 1'b0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef SPEED_RAMP_EN
            ramp_cnt_q    <= 8'd0;
`endif
        end else begin
            lfsr_q       <= lfsr_d;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
            if (state_q != IDLE && bus.abort_i) begin
                state_q       <= IDLE;
                mole_oh_q     <= '0;
                window_left_q <= 3'd0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.start_i) begin
                        state_q      <= ARM;
                        score_q      <= 8'd0;
                        misses_q     <= 8'd0;
                        round_cnt_q  <= 8'd0;
                        cur_window_q <= BASE_WINDOW;
                        arm_cnt_q    <= ARM_DELAY;
                        have_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
`ifdef SPEED_RAMP_EN
                        ramp_cnt_q   <= 8'd0;
`endif
                    end
                    ARM: begin
                        if (arm_cnt_q == 3'd0) begin
                            state_q <= POP;
                        end else if (bus.tick_i) begin
                            arm_cnt_q <= arm_cnt_q - 3'd1;
                            if (arm_cnt_q == 3'd1) state_q <= POP;
                        end
                    end
                    POP: begin
                        mole_oh_q     <= NUM_MOLES'(1) << pop_idx;
                        window_left_q <= cur_window_q;
                        last_idx_q    <= pop_idx;
                        have_last_q   <= 1'b1;
                        state_q       <= UP;
                    end
                    UP: begin
                        // Correct button beats a simultaneous wrong button or expiring tick.
                        if (|(bus.btn_i & mole_oh_q)) begin
                            state_q       <= HIT;
                            hit_pulse_q   <= 1'b1;
                            mole_oh_q     <= '0;
                            window_left_q <= 3'd0;
                            score_q       <= sat_inc(score_q);
                            round_cnt_q   <= round_cnt_q + 8'd1;
`ifdef SPEED_RAMP_EN
                            if (ramp_cnt_q == 8'(RAMP_HITS - 1)) begin
                                ramp_cnt_q <= 8'd0;
                                if (cur_window_q > 3'd1) cur_window_q <= cur_window_q - 3'd1;
                            end else begin
                                ramp_cnt_q <= ramp_cnt_q + 8'd1;
                            end
`endif
                        end else if ((|bus.btn_i) || (bus.tick_i && window_left_q == 3'd1)) begin
                            state_q       <= MISS;
                            miss_pulse_q  <= 1'b1;
                            mole_oh_q     <= '0;
                            window_left_q <= 3'd0;
                            misses_q      <= sat_inc(misses_q);
                            round_cnt_q   <= round_cnt_q + 8'd1;
                        end else if (bus.tick_i) begin
                            window_left_q <= window_left_q - 3'd1;
                        end
                    end
                    HIT, MISS: begin
                        if (round_cnt_q == 8'(NUM_ROUNDS)) begin
                            state_q     <= DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q   <= ARM;
                            arm_cnt_q <= ARM_DELAY;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mole_oh_o     = mole_oh_q;
    assign bus.window_left_o = window_left_q;
    assign bus.score_o       = score_q;
    assign bus.misses_o      = misses_q;
    assign bus.round_cnt_o   = round_cnt_q;
    assign bus.busy_o        = busy_q;
    assign bus.hit_pulse_o   = hit_pulse_q;
    assign bus.miss_pulse_o  = miss_pulse_q;
    assign bus.game_over_o   = game_over_q;
endmodule
